// File: rtl/tree_traversal_engine.sv
// Decision-tree walker. It fetches one node per step and asks the feature selector
// for the node's feature. It compares that feature with the threshold and emits a class or an error.
module tree_traversal_engine #(
   parameter int NODE_AW   = 6,
   parameter int CLASS_W   = 4,
   parameter int MAX_DEPTH = 16,
   parameter int NODE_W    = 36 + 2 * NODE_AW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [NODE_AW-1:0] cfg_addr,
   input  logic [NODE_W-1:0]  cfg_wdata,
   input  logic               start,
   output logic               busy,
   output logic               sel_valid_in,
   output logic [2:0]         sel_feature_id,
   input  logic [31:0]        sel_feature,
   input  logic               sel_valid,
   input  logic               sel_error,
   output logic [CLASS_W-1:0] class_out,
   output logic               class_valid,
   output logic               err_out
);

   localparam int STEP_W = $clog2(MAX_DEPTH + 1);
   localparam logic [STEP_W-1:0] MAX_STEPS = STEP_W'(MAX_DEPTH);
   localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      CHECK = 2'd2,
      WAIT  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [NODE_W-1:0]    mem_r [0:(2**NODE_AW)-1];
   logic [NODE_W-1:0]    node_r, node_s;
   logic [NODE_AW-1:0]   ptr_r, ptr_s;
   logic [STEP_W-1:0]    steps_r, steps_s;
   logic [1:0]           tmo_r, tmo_s;
   logic [CLASS_W-1:0]   class_s;
   logic                 class_valid_s;
   logic                 err_s;

   logic                 node_leaf_s;
   logic [2:0]           node_fid_s;
   logic [NODE_AW-1:0]   node_left_s;
   logic [NODE_AW-1:0]   node_right_s;
   logic [31:0]          node_thr_s;

   assign node_leaf_s  = node_r[NODE_W-1];
   assign node_fid_s   = node_r[NODE_W-2 -: 3];
   assign node_left_s  = node_r[2*NODE_AW+31 -: NODE_AW];
   assign node_right_s = node_r[NODE_AW+31 -: NODE_AW];
   assign node_thr_s   = node_r[31:0];
   assign busy         = (state_r != IDLE);

   // Node table: no reset so contents survive rst_n; writes only while idle
   always_ff @(posedge clk) begin
      if (cfg_we && (state_r == IDLE)) begin
         mem_r[cfg_addr] <= cfg_wdata;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         node_r      <= {NODE_W{1'b0}};
         ptr_r       <= {NODE_AW{1'b0}};
         steps_r     <= {STEP_W{1'b0}};
         tmo_r       <= 2'd0;
         class_out   <= {CLASS_W{1'b0}};
         class_valid <= 1'b0;
         err_out     <= 1'b0;
      end else begin
         state_r     <= state_s;
         node_r      <= node_s;
         ptr_r       <= ptr_s;
         steps_r     <= steps_s;
         tmo_r       <= tmo_s;
         class_out   <= class_s;
         class_valid <= class_valid_s;
         err_out     <= err_s;
      end
   end

   // Next-state, result and selector-request decode
   always_comb begin
      state_s        = state_r;
      node_s         = node_r;
      ptr_s          = ptr_r;
      steps_s        = steps_r;
      tmo_s          = tmo_r;
      class_s        = class_out;
      class_valid_s  = 1'b0;
      err_s          = 1'b0;
      sel_valid_in   = 1'b0;
      sel_feature_id = 3'd0;
      case (state_r)
         IDLE: begin
            if (start) begin
               ptr_s   = {NODE_AW{1'b0}};
               steps_s = {STEP_W{1'b0}};
               state_s = FETCH;
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            node_s  = mem_r[ptr_r];
            state_s = CHECK;
         end
         CHECK: begin
            if (node_leaf_s) begin
               class_s       = node_r[CLASS_W-1:0];
               class_valid_s = 1'b1;
               state_s       = IDLE;
            end else if (steps_r == MAX_STEPS) begin
               class_s       = {CLASS_W{1'b0}};
               class_valid_s = 1'b1;
               err_s         = 1'b1;
               state_s       = IDLE;
            end else begin
               sel_valid_in   = 1'b1;
               sel_feature_id = node_fid_s;
               steps_s        = steps_r + STEP_ONE;
               tmo_s          = 2'd0;
               state_s        = WAIT;
            end
         end
         WAIT: begin
            // Four silent WAIT cycles (tmo 0..3) abort the walk
            if (sel_valid && sel_error) begin
               class_s       = {CLASS_W{1'b0}};
               class_valid_s = 1'b1;
               err_s         = 1'b1;
               state_s       = IDLE;
            end else if (sel_valid) begin
               ptr_s   = ($signed(sel_feature) <= $signed(node_thr_s)) ? node_left_s : node_right_s;
               state_s = FETCH;
            end else if (tmo_r == 2'd3) begin
               class_s       = {CLASS_W{1'b0}};
               class_valid_s = 1'b1;
               err_s         = 1'b1;
               state_s       = IDLE;
            end else begin
               tmo_s = tmo_r + 2'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

endmodule
